dem_tree_ctrl: RTL and testbench

//  Sequencer for the DEM-DAC switching tree: LAYERS ranks of switching_block stages, 2**LAYERS-1 blocks.
//  - Accepts input codes on a valid/ready handshake and feeds them to the tree root.
//  - Generates every block's pn_seq bit from one LFSR, skewed per rank so that all blocks see the same LFSR state for a sample.
//  - Tracks in-flight samples, flags tree output valid, and handles flush and reseed.

---
 rtl/dem_tree_ctrl.sv | 136 +++++++++++++
 tb/tb_dem_tree_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dem_tree_ctrl.sv
// rtl/dem_tree_ctrl.sv - DEM-DAC switching tree sequencer: input handshake, skewed LFSR pn bits, valid tracking
module dem_tree_ctrl #(
    parameter int                WIDTH     = 16,
    parameter int                LAYERS    = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   enable_i,
    input  logic                   dem_en_i,
    input  logic                   flush_i,
    input  logic                   seed_load_i,
    input  logic [LFSR_W-1:0]      seed_i,
    input  logic                   sample_valid_i,
    input  logic [WIDTH-1:0]       sample_i,
    output logic                   sample_ready_o,
    output logic [WIDTH-1:0]       tree_x_o,
    output logic [2**LAYERS-2:0]   pn_seq_o,
    output logic                   tree_valid_o,
    output logic                   busy_o,
    output logic [31:0]            sample_cnt_o
);

    localparam int NBLK = 2**LAYERS - 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_LOAD  = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] SEED_FIX = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    function automatic logic [NBLK-1:0] rank_mask(input int l);
        logic [NBLK-1:0] m;
        m = '0;
        for (int b = 0; b < NBLK; b++) begin
            if (b >= (2**l) - 1 && b <= (2**(l+1)) - 2) m[b] = 1'b1;
        end
        return m;
    endfunction

    logic [1:0]                     state_q, state_d;
    logic [LFSR_W-1:0]              lfsr_q, lfsr_d;
    logic [LAYERS:0]                vld_q, vld_d;
    logic [WIDTH-1:0]               tree_x_q, tree_x_d;
    logic [NBLK-1:0]                pn_q, pn_d;
    logic [31:0]                    cnt_q, cnt_d;
    // snap_q[k] carries the accept-time LFSR snapshot k+1 cycles behind the accept
    logic [LAYERS-2:0][NBLK-1:0]    snap_q, snap_d;

    logic              accept;
    logic [LFSR_W-1:0] lfsr_next;
    logic [LFSR_W-1:0] seed_fix;
    logic [NBLK-1:0]   pn_upd;

    assign accept    = sample_valid_i & (state_q == ST_RUN);
    assign lfsr_next = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    assign seed_fix  = (seed_i == '0) ? LFSR_W'(1) : seed_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_load_i)   state_d = ST_LOAD;
                else if (enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush_i || !enable_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (vld_q == '0 && !accept) state_d = ST_IDLE;
            end
            ST_LOAD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == ST_LOAD) lfsr_d = seed_fix;
        else if (accept)        lfsr_d = lfsr_next;

        vld_d    = {vld_q[LAYERS-1:0], accept};
        tree_x_d = accept ? sample_i : '0;
        cnt_d    = accept ? cnt_q + 32'd1 : cnt_q;

        snap_d    = snap_q;
        snap_d[0] = accept ? lfsr_q[NBLK-1:0] : snap_q[0];
        for (int k = 1; k < LAYERS - 1; k++) begin
            snap_d[k] = snap_q[k-1];
        end

        // each rank refreshes only when a real sample enters it; bubbles leave its bits alone
        pn_upd = pn_q;
        if (accept) begin
            pn_upd = (pn_upd & ~rank_mask(0)) | (lfsr_q[NBLK-1:0] & rank_mask(0));
        end
        for (int l = 1; l < LAYERS; l++) begin
            if (vld_q[l-1]) begin
                pn_upd = (pn_upd & ~rank_mask(l)) | (snap_q[l-1] & rank_mask(l));
            end
        end
        pn_d = dem_en_i ? pn_upd : '1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED_FIX;
            vld_q    <= '0;
            tree_x_q <= '0;
            pn_q     <= '0;
            cnt_q    <= '0;
            snap_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            vld_q    <= vld_d;
            tree_x_q <= tree_x_d;
            pn_q     <= pn_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
        end
    end

    assign sample_ready_o = (state_q == ST_RUN);
    assign tree_x_o       = tree_x_q;
    assign pn_seq_o       = pn_q;
    assign tree_valid_o   = vld_q[LAYERS];
    assign busy_o         = |vld_q;
    assign sample_cnt_o   = cnt_q;

endmodule

// File: tb/tb_dem_tree_ctrl.sv
// tb/tb_dem_tree_ctrl.sv - directed self-checking bench for dem_tree_ctrl
module tb_dem_tree_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        enable_i;
    logic        dem_en_i;
    logic        flush_i;
    logic        seed_load_i;
    logic [15:0] seed_i;
    logic        sample_valid_i;
    logic [15:0] sample_i;
    logic        sample_ready_o;
    logic [15:0] tree_x_o;
    logic [14:0] pn_seq_o;
    logic        tree_valid_o;
    logic        busy_o;
    logic [31:0] sample_cnt_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;
    logic [15:0] hist [0:63];
    int          nh;
    logic [14:0] pn_hold;

    dem_tree_ctrl dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .enable_i       (enable_i),
        .dem_en_i       (dem_en_i),
        .flush_i        (flush_i),
        .seed_load_i    (seed_load_i),
        .seed_i         (seed_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .sample_ready_o (sample_ready_o),
        .tree_x_o       (tree_x_o),
        .pn_seq_o       (pn_seq_o),
        .tree_valid_o   (tree_valid_o),
        .busy_o         (busy_o),
        .sample_cnt_o   (sample_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // expected pn word for an unbroken stream: rank l holds the snapshot of the sample l accepts back
    function automatic logic [14:0] exp_pn();
        logic [14:0] e;
        e = '0;
        for (int l = 0; l < 4; l++) begin
            for (int b = (1 << l) - 1; b <= (1 << (l + 1)) - 2; b++) begin
                e[b] = hist[nh - 1 - l][b];
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic acc_step();
        hist[nh] = m_lfsr;
        nh++;
        m_lfsr = lstep(m_lfsr);
        step();
    endtask

    initial begin
        reset_ni = 1'b0; enable_i = 1'b0; dem_en_i = 1'b0; flush_i = 1'b0;
        seed_load_i = 1'b0; seed_i = '0; sample_valid_i = 1'b0; sample_i = '0;
        m_lfsr = 16'hACE1; nh = 0;
        #3;
        chk("rst_tree_x", 32'(tree_x_o), 32'h0);
        chk("rst_pn", 32'(pn_seq_o), 32'h0);
        chk("rst_valid", 32'(tree_valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(sample_ready_o), 32'h0);
        chk("rst_cnt", sample_cnt_o, 32'h0);
        step(); step();
        reset_ni = 1'b1;
        enable_i = 1'b1; dem_en_i = 1'b1;

        // single sample latency and pn rank fill
        step();
        chk("t1_ready", 32'(sample_ready_o), 32'h1);
        sample_valid_i = 1'b1; sample_i = 16'd100;
        acc_step();
        sample_valid_i = 1'b0;
        chk("t1_tree_x", 32'(tree_x_o), 32'd100);
        chk("t1_cnt", sample_cnt_o, 32'd1);
        chk("t1_pn_e0", 32'(pn_seq_o), 32'h0001);
        chk("t1_valid_e0", 32'(tree_valid_o), 32'h0);
        chk("t1_busy_e0", 32'(busy_o), 32'h1);
        step();
        chk("t1_bubble_x", 32'(tree_x_o), 32'h0);
        chk("t1_valid_e1", 32'(tree_valid_o), 32'h0);
        step();
        chk("t1_pn_e2", 32'(pn_seq_o), 32'h0061);
        step();
        chk("t1_pn_e3", 32'(pn_seq_o), 32'h2CE1);
        chk("t1_valid_e3", 32'(tree_valid_o), 32'h0);
        step();
        chk("t1_valid_e4", 32'(tree_valid_o), 32'h1);
        step();
        chk("t1_valid_e5", 32'(tree_valid_o), 32'h0);
        chk("t1_busy_e5", 32'(busy_o), 32'h0);

        // back-to-back burst of 8
        sample_valid_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i < 8) begin
                sample_i = 16'(i + 1);
                acc_step();
                if (i == 7) sample_valid_i = 1'b0;
                chk("t2_tree_x", 32'(tree_x_o), 32'(i + 1));
                chk("t2_pn0", 32'(pn_seq_o[0]), 32'(hist[nh - 1][0]));
                if (i >= 3) chk("t2_pn_all", 32'(pn_seq_o), 32'(exp_pn()));
            end else begin
                step();
            end
            chk("t2_valid", 32'(tree_valid_o), 32'((i >= 4 && i <= 11) ? 1 : 0));
        end
        chk("t2_pn0_first", 32'(hist[1][0]), 32'h1);
        chk("t2_cnt", sample_cnt_o, 32'd9);

        // flush on the third sample of a burst
        sample_valid_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            flush_i = (j == 2);
            sample_i = 16'(100 + j);
            acc_step();
        end
        flush_i = 1'b0; enable_i = 1'b0;
        chk("t3_ready_drop", 32'(sample_ready_o), 32'h0);
        chk("t3_cnt", sample_cnt_o, 32'd12);
        chk("t3_last_x", 32'(tree_x_o), 32'd102);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t3_busy", 32'(busy_o), 32'((k < 5) ? 1 : 0));
        end
        chk("t3_no_accept", sample_cnt_o, 32'd12);
        sample_valid_i = 1'b0;
        step();

        // reseed with zero in IDLE, then ignored reseed in RUN
        seed_load_i = 1'b1; seed_i = 16'h0000;
        step();
        seed_load_i = 1'b0;
        step();
        m_lfsr = 16'h0001;
        enable_i = 1'b1;
        step();
        chk("t4_ready", 32'(sample_ready_o), 32'h1);
        sample_valid_i = 1'b1; sample_i = 16'd7;
        acc_step();
        sample_valid_i = 1'b0;
        step(); step(); step();
        chk("t4_seed0_pn", 32'(pn_seq_o), 32'h0001);
        seed_load_i = 1'b1; seed_i = 16'h1234;
        step();
        seed_load_i = 1'b0;
        chk("t4_run_ready", 32'(sample_ready_o), 32'h1);
        sample_valid_i = 1'b1; sample_i = 16'd8;
        acc_step();
        sample_valid_i = 1'b0;
        step(); step(); step();
        chk("t4_ignore_pn", 32'(pn_seq_o), 32'h0002);

        // dem_en off and back on during a stream
        sample_valid_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            sample_i = 16'(200 + j);
            acc_step();
        end
        dem_en_i = 1'b0;
        acc_step();
        chk("t5_off_a", 32'(pn_seq_o), 32'h7FFF);
        acc_step();
        chk("t5_off_b", 32'(pn_seq_o), 32'h7FFF);
        dem_en_i = 1'b1;
        acc_step();
        chk("t5_resume", 32'(pn_seq_o), 32'(exp_pn()));
        sample_valid_i = 1'b0;
        step(); step(); step(); step();
        pn_hold = hist[nh - 1][14:0];
        chk("t5_settled", 32'(pn_seq_o), 32'(pn_hold));
        step();
        chk("t5_bubble_hold", 32'(pn_seq_o), 32'(pn_hold));

        // async reset with samples in flight
        sample_valid_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            sample_i = 16'(300 + j);
            acc_step();
        end
        sample_valid_i = 1'b0;
        #2 reset_ni = 1'b0;
        #1;
        chk("t6_tree_x", 32'(tree_x_o), 32'h0);
        chk("t6_pn", 32'(pn_seq_o), 32'h0);
        chk("t6_valid", 32'(tree_valid_o), 32'h0);
        chk("t6_busy", 32'(busy_o), 32'h0);
        chk("t6_ready", 32'(sample_ready_o), 32'h0);
        chk("t6_cnt", sample_cnt_o, 32'h0);
        step();
        reset_ni = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t6_no_pulse", 32'(tree_valid_o), 32'h0);
            chk("t6_no_busy", 32'(busy_o), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
